// File: rtl/piso_arb_pkg.sv
// Shared types and helpers for the two-requester arbitrated PISO serializer.
package piso_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // ceil(log2(n)), minimum 1, for the bit counter width
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/piso_shreg.sv
// N-bit parallel-load shift register, MSB-first serial output, zero fill on shift.
module piso_shreg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [N-1:0] din,
  output logic         sout
);

  logic [N-1:0] sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        sh <= '0;
    else if (load)  sh <= din;
    else if (shift) sh <= {sh[N-2:0], 1'b0};
  end

  assign sout = sh[N-1];

endmodule

// File: rtl/piso_arb_ctrl.sv
// Round-robin arbiter between two word sources feeding one MSB-first serializer,
// with a programmable idle gap between words.
module piso_arb_ctrl
  import piso_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int GAP = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_data,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_data,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         sout,
  output logic         sout_en,
  output logic         grant_id,
  output logic         busy,
  output logic         done
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST     = CW'(N - 1);
  localparam logic [3:0]    GAP_LAST = 4'(GAP - 1);

  state_t         state, state_next;
  logic           ptr, ptr_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [3:0]     gap_cnt, gap_cnt_next;
  logic           grant_next, sout_en_next, busy_next, done_next;
  logic           xfer, win_id;
  logic [N-1:0]   win_data;

  // ptr = 0 favours req0 under contention; a lone valid always wins
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !ptr)) req0_ready = 1'b1;
      else if (req1_valid)                     req1_ready = 1'b1;
    end
  end

  assign xfer     = req0_ready || req1_ready;
  assign win_id   = req1_ready;
  assign win_data = req1_ready ? req1_data : req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (xfer) state_next = SHIFT;
      SHIFT: if (cnt == LAST) state_next = (GAP == 0) ? IDLE : piso_arb_pkg::GAP;
      piso_arb_pkg::GAP: if (gap_cnt == GAP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state
  always_comb begin
    cnt_next     = cnt;
    gap_cnt_next = gap_cnt;
    ptr_next     = ptr;
    grant_next   = grant_id;
    if (xfer) begin
      cnt_next   = '0;
      ptr_next   = ~win_id;
      grant_next = win_id;
    end else if (state == SHIFT && cnt != LAST) begin
      cnt_next = cnt + CW'(1);
    end
    if (state == SHIFT)                  gap_cnt_next = '0;
    else if (state == piso_arb_pkg::GAP) gap_cnt_next = gap_cnt + 4'd1;
    sout_en_next = (state_next == SHIFT);
    busy_next    = (state_next != IDLE);
    done_next    = (state_next == SHIFT) && (cnt_next == LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= 1'b0;
      cnt      <= '0;
      gap_cnt  <= '0;
      grant_id <= 1'b0;
      sout_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ptr      <= ptr_next;
      cnt      <= cnt_next;
      gap_cnt  <= gap_cnt_next;
      grant_id <= grant_next;
      sout_en  <= sout_en_next;
      busy     <= busy_next;
      done     <= done_next;
    end
  end

  // Shifting on the final bit edge leaves the register zero, so sout idles low
  piso_shreg #(
    .N(N)
  ) u_shreg (
    .clk  (clk),
    .rst  (rst),
    .load (xfer),
    .shift(state == SHIFT),
    .din  (win_data),
    .sout (sout)
  );

endmodule
